core_mem_arbiter: RTL and testbench
===================================

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, max consecutive data grants issued while inst_read is pending before an instruction grant is forced; legal range 1-15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 inst_read  input  1  core instruction fetch request, held until inst_resp.
REQ-005 inst_addr  input  32  fetch byte address.
REQ-006 inst_resp  output  1  one-cycle fetch completion pulse.
REQ-007 inst_rdata  output  32  fetched word, valid with inst_resp.
REQ-008 data_read, data_write  input  1 each  core data request, held until data_resp.
REQ-009 data_mbe  input  4  byte enables for writes.
REQ-010 data_addr, data_wdata  input  32 each  data byte address, write data.
REQ-011 data_resp  output  1  one-cycle data completion pulse.
REQ-012 data_rdata  output  32  loaded word, valid with data_resp.
REQ-013 mem_read, mem_write  output  1 each  memory-side request, held until mem_resp.
REQ-014 mem_mbe  output  4  memory byte enables.
REQ-015 mem_addr, mem_wdata  output  32 each  word-aligned address, write data.
REQ-016 mem_resp  input  1  memory completion, one cycle.
REQ-017 mem_rdata  input  32  memory read data, valid with mem_resp.

Function
REQ-018 FSM states IDLE, I_ACCESS, D_ACCESS, DONE; only one memory transaction outstanding at any time.
REQ-019 IDLE: data request pending and (inst_read low or starve_cnt < STARVE_LIMIT) -> D_ACCESS; else inst_read high -> I_ACCESS; else stay.
REQ-020 On grant, request fields (op, addr, wdata, mbe, source) SHALL be registered; memory outputs driven only from these registers.
REQ-021 mem_addr = latched address with bits [1:0] forced to 0.
REQ-022 mem_mbe = 4'hF for instruction fetches and data reads; latched data_mbe for writes; mem_wdata = latched data_wdata for writes, 0 otherwise.
REQ-023 data_read and data_write both high at grant: treated as write; read ignored.
REQ-024 Write with data_mbe = 4'h0: no memory request issued; FSM goes D_ACCESS -> DONE next cycle.
REQ-025 In I_ACCESS/D_ACCESS, mem_read/mem_write held asserted until mem_resp; on mem_resp, mem_rdata captured, memory request deasserted next cycle, next state DONE.
REQ-026 DONE: exactly one of inst_resp/data_resp high for this one cycle (matching source); next state IDLE unconditionally (no grant from DONE, preventing re-service of a request the core drops this edge).
REQ-027 Latency: request seen in IDLE at cycle 0 -> memory request asserted cycle 1 -> mem_resp at cycle k -> core resp at cycle k+1 -> IDLE at k+2.
REQ-028 inst_rdata/data_rdata registered; updated only on own completion (data_rdata not updated for writes); hold value otherwise.
REQ-029 starve_cnt (4 bits): D grant with inst_read high -> increment, saturate at STARVE_LIMIT; D grant with inst_read low -> 0; I grant -> 0.
REQ-030 mem_resp in IDLE or DONE ignored, no state change.
REQ-031 Core request deasserted during an access: transaction completes and resp still pulses.

Reset
REQ-032 rst low SHALL immediately, regardless of clock, force state IDLE, starve_cnt 0, all outputs 0 (inst_resp, data_resp, inst_rdata, data_rdata, mem_read, mem_write, mem_mbe, mem_addr, mem_wdata).
REQ-033 Reset mid-access abandons outstanding memory transaction; no core response issued for it; first grant occurs no earlier than first rising edge after rst returns high.

Verification
REQ-034 Fetch: inst_read=1, inst_addr=0x6000_0006, mem_resp after 3 cycles with 0x0000_0013 -> mem_read=1, mem_addr=0x6000_0004, mem_mbe=F for 3 cycles; inst_resp one cycle later with inst_rdata=0x0000_0013.
REQ-035 Store: data_write=1, data_mbe=4'b0011, addr 0x100, wdata 0xDEAD_BEEF -> mem_write=1, mem_mbe=3, mem_wdata=0xDEAD_BEEF; data_resp one pulse; data_rdata unchanged.
REQ-036 Contention with STARVE_LIMIT=2: inst_read and data_read held continuously -> grant order D, D, I, D, D, I.
REQ-037 Simultaneous data_read=data_write=1, mbe=4'h0 -> no mem_read/mem_write ever asserted; data_resp 2 cycles after grant.
REQ-038 rst driven low mid D_ACCESS between clock edges -> mem_read and all outputs 0 before next edge; later mem_resp=1 ignored; no data_resp.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Single-port memory arbiter between a core's instruction-fetch and data ports.
// One transaction in flight; data is favoured, but bounded so fetches cannot starve.
module core_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_read,
    input  logic [31:0] inst_addr,
    output logic        inst_resp,
    output logic [31:0] inst_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_resp,
    output logic [31:0] data_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_mbe,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, I_ACCESS, D_ACCESS, DONE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      r_state, w_next;
    logic        w_data_req, w_grant_d, w_grant_i, w_finish;
    logic [3:0]  r_starve;
    logic        r_src_d, r_wr, r_skip;
    logic        r_mem_read, r_mem_write;
    logic [3:0]  r_mbe;
    logic [31:0] r_addr, r_wdata;
    logic        r_inst_resp, r_data_resp;
    logic [31:0] r_inst_rdata, r_data_rdata;

    assign w_data_req = data_read | data_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_data_req && (!inst_read || r_starve < LIMIT)) begin
                    w_grant_d = 1'b1;
                    w_next    = D_ACCESS;
                end else if (inst_read) begin
                    w_grant_i = 1'b1;
                    w_next    = I_ACCESS;
                end
            end
            I_ACCESS: begin
                if (mem_resp) begin
                    w_finish = 1'b1;
                    w_next   = DONE;
                end
            end
            D_ACCESS: begin
                // zero-enable writes never reach memory and retire on their own
                if (r_skip || mem_resp) begin
                    w_finish = 1'b1;
                    w_next   = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve     <= 4'd0;
            r_src_d      <= 1'b0;
            r_wr         <= 1'b0;
            r_skip       <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mbe        <= 4'h0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_inst_resp  <= 1'b0;
            r_data_resp  <= 1'b0;
            r_inst_rdata <= 32'h0;
            r_data_rdata <= 32'h0;
        end else begin
            r_inst_resp <= 1'b0;
            r_data_resp <= 1'b0;
            if (w_grant_d) begin
                r_src_d     <= 1'b1;
                r_wr        <= data_write;
                r_skip      <= data_write && (data_mbe == 4'h0);
                r_addr      <= data_addr & 32'hFFFF_FFFC;
                r_wdata     <= data_write ? data_wdata : 32'h0;
                r_mbe       <= data_write ? data_mbe : 4'hF;
                r_mem_read  <= !data_write;
                r_mem_write <= data_write && (data_mbe != 4'h0);
                if (inst_read)
                    r_starve <= (r_starve >= LIMIT) ? LIMIT : r_starve + 4'd1;
                else
                    r_starve <= 4'd0;
            end
            if (w_grant_i) begin
                r_src_d     <= 1'b0;
                r_wr        <= 1'b0;
                r_skip      <= 1'b0;
                r_addr      <= inst_addr & 32'hFFFF_FFFC;
                r_wdata     <= 32'h0;
                r_mbe       <= 4'hF;
                r_mem_read  <= 1'b1;
                r_mem_write <= 1'b0;
                r_starve    <= 4'd0;
            end
            if (w_finish) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                if (r_src_d) begin
                    r_data_resp <= 1'b1;
                    if (!r_wr) r_data_rdata <= mem_rdata;
                end else begin
                    r_inst_resp  <= 1'b1;
                    r_inst_rdata <= mem_rdata;
                end
            end
        end
    end

    assign inst_resp  = r_inst_resp;
    assign inst_rdata = r_inst_rdata;
    assign data_resp  = r_data_resp;
    assign data_rdata = r_data_rdata;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_mbe    = r_mbe;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: vector table with a response scoreboard, then
// contention and asynchronous-reset sequences.
module tb_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        data_read, data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_addr, data_wdata;
    logic        data_resp;
    logic [31:0] data_rdata;
    logic        mem_read, mem_write;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    core_mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .inst_read(inst_read), .inst_addr(inst_addr),
        .inst_resp(inst_resp), .inst_rdata(inst_rdata),
        .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_resp(data_resp), .data_rdata(data_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_mbe(mem_mbe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        inst, rd, wr, drop;
        logic [31:0] addr, wdata;
        logic [3:0]  mbe;
        int          lat;
        logic [31:0] mrdata;
        logic        e_rd, e_wr;
        logic [31:0] e_addr;
        logic [3:0]  e_mbe;
        logic [31:0] e_wdata;
    } vec_t;

    typedef struct {
        logic        src_d;
        logic [31:0] rdata;
    } exp_t;

    vec_t        vecs[7];
    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model_drd = 32'h0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic drop_reqs();
        inst_read  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   n_mem;
        bit   got;
        bit   skip;
        exp_t e;
        skip = !v.e_rd && !v.e_wr;
        @(negedge clk);
        inst_read  = v.inst;
        inst_addr  = v.inst ? v.addr : 32'h0;
        data_read  = v.rd;
        data_write = v.wr;
        data_addr  = v.addr;
        data_wdata = v.wdata;
        data_mbe   = v.mbe;
        if (!v.inst && !v.wr) model_drd = v.mrdata;
        e.src_d = !v.inst;
        e.rdata = v.inst ? v.mrdata : model_drd;
        sbq.push_back(e);
        n_mem = 0;
        got   = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk); #1;
            mem_resp = 1'b0;
            if (v.drop && c == 1) drop_reqs();
            if (mem_read || mem_write) begin
                n_mem++;
                if (n_mem == 1) begin
                    chk($sformatf("v%0d mem_read", idx), 32'(mem_read), 32'(v.e_rd));
                    chk($sformatf("v%0d mem_write", idx), 32'(mem_write), 32'(v.e_wr));
                    chk($sformatf("v%0d mem_addr", idx), mem_addr, v.e_addr);
                    chk($sformatf("v%0d mem_mbe", idx), 32'(mem_mbe), 32'(v.e_mbe));
                    chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
                end
                if (n_mem == v.lat) begin
                    mem_resp  = 1'b1;
                    mem_rdata = v.mrdata;
                end
            end
            if (inst_resp || data_resp) begin
                got = 1;
                drop_reqs();
                e = sbq.pop_front();
                chk($sformatf("v%0d resp_src", idx), 32'({inst_resp, data_resp}),
                    e.src_d ? 32'd1 : 32'd2);
                chk($sformatf("v%0d rdata", idx), e.src_d ? data_rdata : inst_rdata, e.rdata);
                chk($sformatf("v%0d latency", idx), 32'(c), skip ? 32'd2 : 32'(v.lat + 1));
                chk($sformatf("v%0d mem_cycles", idx), 32'(n_mem), skip ? 32'd0 : 32'(v.lat));
            end
        end
        if (!got) begin
            chk($sformatf("v%0d resp_timeout", idx), 32'd0, 32'd1);
            drop_reqs();
            void'(sbq.pop_front());
        end
        mem_resp = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d resp_one_cycle", idx), 32'({inst_resp, data_resp}), 32'd0);
    endtask

    initial begin
        logic grants[6];
        logic exp_g[6];
        int   ng;
        logic prev_rd;

        //           inst  rd    wr    drop  addr           wdata          mbe   lat mrdata         e_rd  e_wr  e_addr         e_mbe e_wdata
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h6000_0006, 32'h0,         4'h0, 3, 32'h0000_0013, 1'b1, 1'b0, 32'h6000_0004, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0203, 32'h1111_1111, 4'h5, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 2, 32'h5555_5555, 1'b0, 1'b1, 32'h0000_0100, 4'h3, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0180, 32'h7777_7777, 4'h0, 1, 32'h6666_6666, 1'b0, 1'b0, 32'h0,         4'h0, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0042, 32'h1234_5678, 4'hC, 1, 32'h9999_9999, 1'b0, 1'b1, 32'h0000_0040, 4'hC, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         4'h0, 5, 32'hA5A5_5A5A, 1'b1, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0007, 32'h0,         4'hF, 2, 32'h0BAD_C0DE, 1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'h0};

        rst = 1'b0;
        drop_reqs();
        inst_addr  = 32'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        data_mbe   = 4'h0;
        mem_resp   = 1'b0;
        mem_rdata  = 32'h0;
        #12;
        chk("rst mem_read", 32'(mem_read), 32'd0);
        chk("rst mem_write", 32'(mem_write), 32'd0);
        chk("rst mem_mbe", 32'(mem_mbe), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst resp", 32'({inst_resp, data_resp}), 32'd0);
        chk("rst rdata", inst_rdata | data_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Fetch and data requests held together: data wins twice, then fetch is forced.
        exp_g = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        inst_read  = 1'b1;
        inst_addr  = 32'h0000_1000;
        data_read  = 1'b1;
        data_addr  = 32'h0000_2000;
        ng      = 0;
        prev_rd = 1'b0;
        for (int c = 0; c < 100 && ng < 6; c++) begin
            @(posedge clk); #1;
            mem_resp = 1'b0;
            if (mem_read && !prev_rd) begin
                grants[ng] = (mem_addr == 32'h0000_2000);
                ng++;
            end
            if (mem_read) begin
                mem_resp  = 1'b1;
                mem_rdata = mem_addr ^ 32'hFF00_FF00;
            end
            prev_rd = mem_read;
        end
        drop_reqs();
        chk("contention grant count", 32'(ng), 32'd6);
        for (int g = 0; g < ng; g++)
            chk($sformatf("contention grant%0d is_data", g), 32'(grants[g]), 32'(exp_g[g]));
        repeat (4) begin
            @(posedge clk); #1;
            mem_resp = 1'b0;
        end
        chk("contention drained", 32'({mem_read, mem_write}), 32'd0);

        // Asynchronous reset in the middle of a data access.
        @(negedge clk);
        data_read = 1'b1;
        data_addr = 32'h0000_0300;
        @(posedge clk); #1;
        chk("arst pre mem_read", 32'(mem_read), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst mem_read", 32'(mem_read), 32'd0);
        chk("arst mem_addr", mem_addr, 32'd0);
        chk("arst mem_mbe", 32'(mem_mbe), 32'd0);
        chk("arst inst_rdata", inst_rdata, 32'd0);
        chk("arst data_rdata", data_rdata, 32'd0);
        @(negedge clk);
        data_read = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            mem_resp  = (c == 0);
            mem_rdata = 32'hBEEF_0000;
            chk($sformatf("arst after%0d", c), 32'({data_resp, inst_resp, mem_read, mem_write}), 32'd0);
        end
        mem_resp = 1'b0;
        chk("arst data_rdata held", data_rdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
